// File: rtl/pab_pkg.sv
// Shared types for the PAB memory controller: FSM state encoding and operation code.
package pab_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_DROP   = 3'd4
    } pab_mc_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } pab_op_t;

    // Wide enough for the largest wait-state load value (15).
    localparam int WCNT_W = 4;

endpackage

// File: rtl/pab_waitcnt.sv
// Wait-state down-counter: loads a start value, decrements to zero and flags zero.
module pab_waitcnt
    import pab_pkg::*;
#(
    parameter int W = WCNT_W
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/pab_mem_ctrl.sv
// PAB-to-synchronous-RAM controller: one request at a time, fixed-latency response.
// Optional address range checking is enabled with the PAB_RANGE_CHECK_EN macro.
module pab_mem_ctrl
    import pab_pkg::*;
#(
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          PAB_VALID,
    input  logic          PAB_RD,
    input  logic          PAB_WR,
    input  logic [31:0]   PAB_ADDR,
    input  logic [31:0]   PAB_DATA,
    input  logic [3:0]    PAB_BE,
    output logic          MEM_READY,
    output logic          MEM_VALID,
    output logic [31:0]   MEM_DATA,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_ADDR,
    output logic [31:0]   RAM_WDATA,
    input  logic [31:0]   RAM_RDATA,
    output logic          ERR
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES - 1);

    pab_mc_state_t     state, next_state;
    pab_op_t           op_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       data_q;
    logic [3:0]        be_q;
    logic              oor_q;
    logic              err_q;
    logic [31:0]       mem_data_q;
    logic              accept;
    logic              out_of_range;
    logic              ram_en;
    logic [WCNT_W-1:0] wait_count;
    logic              wait_zero;

    assign accept = PAB_VALID && (PAB_RD || PAB_WR);

`ifdef PAB_RANGE_CHECK_EN
    assign out_of_range = |PAB_ADDR[31:AW+2];
    logic unused_addr;
    assign unused_addr = ^PAB_ADDR[1:0];
`else
    // Upper address bits are dropped, so the RAM aliases modulo 2^AW words.
    assign out_of_range = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{PAB_ADDR[31:AW+2], PAB_ADDR[1:0]};
`endif

    pab_waitcnt #(
        .W(WCNT_W)
    ) u_waitcnt (
        .clk      (CLK),
        .res      (RES),
        .load     (state == ST_ACCESS),
        .load_val (WAIT_LOAD),
        .dec      (state == ST_WAIT),
        .count    (wait_count),
        .zero     (wait_zero)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            oor_q      <= 1'b0;
            err_q      <= 1'b0;
            mem_data_q <= '0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && accept) begin
                op_q   <= PAB_WR ? OP_WRITE : OP_READ;
                addr_q <= PAB_ADDR[AW+1:2];
                data_q <= PAB_DATA;
                be_q   <= PAB_BE;
                oor_q  <= out_of_range;
                if (out_of_range) begin
                    err_q <= 1'b1;
                end
            end
            // RAM read data is valid during the first wait cycle only.
            if ((state == ST_WAIT) && (wait_count == WAIT_LOAD)) begin
                mem_data_q <= ((op_q == OP_READ) && !oor_q) ? RAM_RDATA : '0;
            end
        end
    end

    // NOTE: assign next_state before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (accept)     next_state = ST_ACCESS;
            ST_ACCESS:                 next_state = ST_WAIT;
            ST_WAIT:   if (wait_zero)  next_state = ST_RESP;
            ST_RESP:                   next_state = ST_DROP;
            ST_DROP:   if (!PAB_VALID) next_state = ST_IDLE;
            default:                   next_state = ST_IDLE;
        endcase
    end

    // Strobes are also gated by RES so an aborted access never reaches the RAM.
    assign ram_en    = (state == ST_ACCESS) && !oor_q && !RES;
    assign RAM_EN    = ram_en;
    assign RAM_WE    = (ram_en && (op_q == OP_WRITE)) ? be_q : 4'b0000;
    assign RAM_ADDR  = addr_q;
    assign RAM_WDATA = data_q;
    assign MEM_READY = (state == ST_IDLE);
    assign MEM_VALID = (state == ST_RESP) && !RES;
    assign MEM_DATA  = mem_data_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_pab_mem_ctrl.sv
// Directed bench for pab_mem_ctrl: table of single transactions plus reset,
// held-request, idle-valid and address-wrap / range-check sequences.
module tb_pab_mem_ctrl;

    localparam int AW = 12;

    logic          clk;
    logic          res;
    logic          pab_valid, pab_rd, pab_wr;
    logic [31:0]   pab_addr, pab_data;
    logic [3:0]    pab_be;
    logic          mem_ready, mem_valid;
    logic [31:0]   mem_data;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          err;

    // Second instance with four wait states for the held-request case.
    logic          v4, rd4;
    logic [31:0]   addr4;
    logic          ready4, valid4, en4, err4;
    logic [31:0]   data4, wdata4, rdata4;
    logic [3:0]    we4;
    logic [AW-1:0] raddr4;

    int checks = 0;
    int errors = 0;

    pab_mem_ctrl #(.AW(AW), .WAIT_CYCLES(1)) u_dut (
        .CLK(clk), .RES(res), .PAB_VALID(pab_valid), .PAB_RD(pab_rd), .PAB_WR(pab_wr),
        .PAB_ADDR(pab_addr), .PAB_DATA(pab_data), .PAB_BE(pab_be),
        .MEM_READY(mem_ready), .MEM_VALID(mem_valid), .MEM_DATA(mem_data),
        .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata),
        .RAM_RDATA(ram_rdata), .ERR(err)
    );

    pab_mem_ctrl #(.AW(AW), .WAIT_CYCLES(4)) u_dut4 (
        .CLK(clk), .RES(res), .PAB_VALID(v4), .PAB_RD(rd4), .PAB_WR(1'b0),
        .PAB_ADDR(addr4), .PAB_DATA(32'h0), .PAB_BE(4'h0),
        .MEM_READY(ready4), .MEM_VALID(valid4), .MEM_DATA(data4),
        .RAM_EN(en4), .RAM_WE(we4), .RAM_ADDR(raddr4), .RAM_WDATA(wdata4),
        .RAM_RDATA(rdata4), .ERR(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-writable synchronous RAM, one-cycle read latency.
    logic [31:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram_rdata = 32'h0;
        rdata4    = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end
    always @(posedge clk) if (en4) rdata4 <= {20'h0, raddr4};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE, hold it until MEM_VALID, wait until ready again.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input bit scramble,
                           output int lat, output logic [31:0] resp, output int en_cnt,
                           output int vld_cnt, output logic [3:0] we_seen,
                           output logic [AW-1:0] addr_seen, output logic [31:0] wdata_seen);
        bit done;
        lat = -1; resp = 32'hx; en_cnt = 0; vld_cnt = 0;
        we_seen = 4'h0; addr_seen = '0; wdata_seen = 32'h0; done = 1'b0;
        pab_valid = 1'b1; pab_rd = rd; pab_wr = wr;
        pab_addr = addr; pab_data = data; pab_be = be;
        for (int c = 1; c <= 40 && !done; c++) begin
            step();
            if (ram_en) begin
                en_cnt++;
                we_seen = ram_we; addr_seen = ram_addr; wdata_seen = ram_wdata;
            end
            if (c == 1 && scramble) begin
                pab_addr = ~addr; pab_data = ~data; pab_be = ~be; pab_rd = ~rd; pab_wr = ~wr;
            end
            if (mem_valid) begin
                vld_cnt++;
                if (lat < 0) begin
                    lat = c;
                    resp = mem_data;
                end
                pab_valid = 1'b0;
            end
            if (lat > 0 && mem_ready) done = 1'b1;
        end
        pab_valid = 1'b0; pab_rd = 1'b0; pab_wr = 1'b0;
    endtask

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    be;
        bit            scramble;
        logic [31:0]   exp_data;
        logic [3:0]    exp_we;
        logic [AW-1:0] exp_word;
    } vec_t;

    vec_t vecs [12];

    int            lat, en_cnt, vld_cnt, cnt_a, cnt_b, first_v, first_r;
    logic [31:0]   rdat, wd;
    logic [3:0]    we;
    logic [AW-1:0] wa;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         4'hF, 12'h004};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h1234_5678, 4'h0, 12'h004};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_AB00, 4'h2, 1'b1, 32'h0,         4'h2, 12'h004};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h1234_AB78, 4'h0, 12'h004};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,         4'h0, 12'h004};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h1234_AB78, 4'h0, 12'h004};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         4'hF, 12'h008};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 4'h0, 12'h008};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_3FFC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0,         4'hF, 12'hFFF};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 1'b0, 32'h0BAD_F00D, 4'h0, 12'hFFF};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h5A5A_0001, 4'hF, 1'b0, 32'h0,         4'hF, 12'h000};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h5A5A_0001, 4'h0, 12'h000};

        res = 1'b1;
        pab_valid = 1'b0; pab_rd = 1'b0; pab_wr = 1'b0;
        pab_addr = 32'h0; pab_data = 32'h0; pab_be = 4'h0;
        v4 = 1'b0; rd4 = 1'b0; addr4 = 32'h0;

        // Reset state.
        step(); step();
        check("rst_ready", {31'h0, mem_ready}, 32'h1);
        check("rst_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_data", mem_data, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_ram_we", {28'h0, ram_we}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        res = 1'b0;
        step();
        check("ready_after_rst", {31'h0, mem_ready}, 32'h1);

        // Valid with neither RD nor WR: nothing happens.
        pab_valid = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ram_en) cnt_a++;
            if (!mem_ready || mem_valid) cnt_b++;
        end
        pab_valid = 1'b0;
        check("noop_ram_en", cnt_a, 0);
        check("noop_state", cnt_b, 0);

        // Single-transaction table.
        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                    vecs[i].scramble, lat, rdat, en_cnt, vld_cnt, we, wa, wd);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_valid_cnt", i), vld_cnt, 1);
            check($sformatf("v%0d_ram_en_cnt", i), en_cnt, 1);
            check($sformatf("v%0d_ram_we", i), {28'h0, we}, {28'h0, vecs[i].exp_we});
            check($sformatf("v%0d_ram_addr", i), {20'h0, wa}, {20'h0, vecs[i].exp_word});
            check($sformatf("v%0d_resp_data", i), rdat, vecs[i].exp_data);
            check($sformatf("v%0d_data_held", i), mem_data, vecs[i].exp_data);
            if (vecs[i].wr) check($sformatf("v%0d_wdata", i), wd, vecs[i].data);
        end

        // Request held for 10 cycles on the four-wait-state instance.
        v4 = 1'b1; rd4 = 1'b1; addr4 = 32'h0000_0ABC;
        cnt_a = 0; cnt_b = 0; first_v = -1; first_r = -1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (en4) cnt_a++;
            if (valid4) begin
                cnt_b++;
                if (first_v < 0) first_v = c;
            end
            if (ready4 && first_r < 0) first_r = c;
            if (c == 10) v4 = 1'b0;
        end
        rd4 = 1'b0;
        check("held_ram_en_cnt", cnt_a, 1);
        check("held_valid_cnt", cnt_b, 1);
        check("held_valid_cycle", first_v, 6);
        check("held_ready_cycle", first_r, 11);
        check("held_data", data4, 32'h0000_02AF);

        // Address above the RAM size.
        run_req(1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, lat, rdat, en_cnt, vld_cnt, we, wa, wd);
        check("oor_latency", lat, 3);
`ifdef PAB_RANGE_CHECK_EN
        check("oor_ram_en_cnt", en_cnt, 0);
        check("oor_data", rdat, 32'h0);
        check("oor_err", {31'h0, err}, 32'h1);
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, lat, rdat, en_cnt, vld_cnt, we, wa, wd);
        check("err_sticky", {31'h0, err}, 32'h1);
        check("after_oor_data", rdat, 32'h1234_AB78);
`else
        check("wrap_ram_en_cnt", en_cnt, 1);
        check("wrap_ram_addr", {20'h0, wa}, 32'h0);
        check("wrap_data", rdat, 32'h5A5A_0001);
        check("wrap_err", {31'h0, err}, 32'h0);
`endif

        // Reset during the ACCESS cycle of a write: RAM must not be touched.
        pab_valid = 1'b1; pab_wr = 1'b1; pab_rd = 1'b0;
        pab_addr = 32'h0000_0020; pab_data = 32'h1111_1111; pab_be = 4'hF;
        step();
        check("abort_access_en_before", {31'h0, ram_en}, 32'h1);
        res = 1'b1; pab_valid = 1'b0; pab_wr = 1'b0;
        #1;
        check("abort_access_en", {31'h0, ram_en}, 32'h0);
        step();
        check("abort_access_ready", {31'h0, mem_ready}, 32'h1);
        check("abort_access_err", {31'h0, err}, 32'h0);
        check("abort_access_data", mem_data, 32'h0);
        res = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mem_valid) cnt_a++;
            if (!mem_ready) cnt_b++;
        end
        check("abort_access_no_valid", cnt_a, 0);
        check("abort_access_idle", cnt_b, 0);
        run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, lat, rdat, en_cnt, vld_cnt, we, wa, wd);
        check("abort_access_ram_kept", rdat, 32'hDEAD_BEEF);

        // Reset during the wait cycle of a write: no response.
        pab_valid = 1'b1; pab_wr = 1'b1;
        pab_addr = 32'h0000_0030; pab_data = 32'h3333_3333; pab_be = 4'hF;
        step(); step();
        res = 1'b1; pab_valid = 1'b0; pab_wr = 1'b0;
        step();
        res = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mem_valid) cnt_a++;
            if (!mem_ready) cnt_b++;
        end
        check("abort_wait_no_valid", cnt_a, 0);
        check("abort_wait_ready", cnt_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
